// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } haz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-operand producer comparator {ex_hit, mem_hit, load_hit}
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              ex_hit,
  output logic              mem_hit,
  output logic              load_hit
);

  logic live;

  // r0 is hardwired zero, so it never matches a producer
  assign live     = used && (src != REG_AW'(REG_ZERO));
  assign ex_hit   = live && ex_valid && ex_regwrite && (ex_dest == src);
  assign mem_hit  = live && mem_valid && mem_regwrite && (mem_dest == src);
  assign load_hit = ex_hit && ex_memread;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding select and load-use stall controller
// Optional HAZARD_STATS_EN adds saturating fwd_count/stall_count outputs.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      ex_valid,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_dest,
  input  logic                      mem_valid,
  input  logic                      mem_regwrite,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      freeze,
  input  logic                      flush,
  output logic                      stall_if_id,
  output logic                      bubble_ex,
  output logic [2*NUM_SRC-1:0]      fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               fwd_count,
  output logic [31:0]               stall_count
`endif
);

  localparam int CNT_W = 2;

  logic [NUM_SRC-1:0]   ex_hit;
  logic [NUM_SRC-1:0]   mem_hit;
  logic [NUM_SRC-1:0]   load_hit;
  logic [2*NUM_SRC-1:0] sel_comb;
  logic [2*NUM_SRC-1:0] sel_next;
  haz_state_t           state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 detect;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_src_match #(.REG_AW(REG_AW)) u_match (
      .src         (id_src[gi*REG_AW +: REG_AW]),
      .used        (id_src_used[gi]),
      .ex_valid    (ex_valid),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_dest     (ex_dest),
      .mem_valid   (mem_valid),
      .mem_regwrite(mem_regwrite),
      .mem_dest    (mem_dest),
      .ex_hit      (ex_hit[gi]),
      .mem_hit     (mem_hit[gi]),
      .load_hit    (load_hit[gi])
    );
    // EX producer will be in EX/MEM when this consumer reaches EX
    assign sel_comb[2*gi +: 2] = ex_hit[gi]  ? FWD_EXMEM :
                                 mem_hit[gi] ? FWD_MEMWB : FWD_RF;
  end

  assign detect = (state == IDLE) && id_valid && !flush && !freeze && (|load_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (freeze) begin
      state_next = state;
    end else if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (detect && (LOAD_BUBBLES > 1)) begin
            state_next = STALL;
            cnt_next   = CNT_W'(LOAD_BUBBLES - 1);
          end
        end
        STALL: begin
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    if (rst_n && !freeze && !flush && ((state == STALL) || detect)) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  assign sel_next = (bubble_ex || flush) ? '0 : sel_comb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_sel <= '0;
    else if (!freeze) fwd_sel <= sel_next;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (!freeze && (|sel_next) && (fwd_count != 32'hFFFF_FFFF))
        fwd_count <= fwd_count + 32'd1;
      if (stall_if_id && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
